// File: rtl/instr_mem_ctrl.sv
// -----------------------------------------------------------------------------
// instr_mem_ctrl
//   Byte-addressed instruction memory with a multi-cycle fetch path, a
//   one-word fetch buffer and a program-load port. Words are little-endian:
//   byte PC is the least significant byte of INSTRUCTION.
//
//   A fetch that matches the buffered word (hit) returns combinationally. Any
//   other fetch stalls the CPU through BUSYWAIT for LATENCY+1 cycles while the
//   word is assembled from the byte array and captured into the buffer.
//
// Parameters
//   ADDR_W      : PC / load address width
//   DEPTH_BYTES : array size in bytes (multiple of WORD_BYTES)
//   WORD_BYTES  : bytes per instruction word
//   LATENCY     : clock edges from an accepted miss to valid data (>= 1)
//
// Ports
//   CLK         : clock, rising edge
//   RESET       : synchronous reset, active low
//   PC          : fetch byte address
//   READ        : fetch request (level)
//   INSTRUCTION : buffered instruction word
//   BUSYWAIT    : CPU stall request
//   FAULT       : last completed fetch was misaligned or out of range
//   LOAD_EN     : write one word this cycle
//   LOAD_ADDR   : byte address of the load
//   LOAD_DATA   : word to write
// -----------------------------------------------------------------------------
module instr_mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int WORD_BYTES  = 4,
  parameter int LATENCY     = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [ADDR_W-1:0]       PC,
  input  logic                    READ,
  output logic [8*WORD_BYTES-1:0] INSTRUCTION,
  output logic                    BUSYWAIT,
  output logic                    FAULT,
  input  logic                    LOAD_EN,
  input  logic [ADDR_W-1:0]       LOAD_ADDR,
  input  logic [8*WORD_BYTES-1:0] LOAD_DATA
);

  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int IDX_W  = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int CNT_W  = $clog2(LATENCY + 1);

  // One extra bit so that addr + WORD_BYTES cannot wrap at the top of the
  // address space and sneak past the range check.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH_BYTES);
  localparam logic [ADDR_W:0] WORD_EXT  = (ADDR_W + 1)'(WORD_BYTES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // True when a word access at this byte address is misaligned or would run
  // past the end of the array.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] a_ext;
    a_ext = {1'b0, a};
    return ((a_ext % WORD_EXT) != '0) || ((a_ext + WORD_EXT) > DEPTH_EXT);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [ADDR_W-1:0]   r_req_pc;

  logic [7:0]          r_mem [DEPTH_BYTES];

  logic [DATA_W-1:0]   r_buf_data;
  logic [ADDR_W-1:0]   r_buf_tag;
  logic                r_buf_valid;
  logic                r_fault;

  logic                w_hit;
  logic                w_accept;
  logic                w_complete;
  logic                w_req_err;
  logic                w_ld_ok;
  logic [DATA_W-1:0]   w_rd_word;

  assign w_hit     = READ && r_buf_valid && (PC == r_buf_tag);
  assign w_req_err = addr_bad(r_req_pc);
  assign w_ld_ok   = LOAD_EN && !addr_bad(LOAD_ADDR);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    BUSYWAIT    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (READ && !w_hit) begin
          BUSYWAIT    = 1'b1;
          w_accept    = 1'b1;
          w_cnt_nxt   = CNT_W'(LATENCY);
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        // PC and READ are ignored here: the accepted request always finishes.
        BUSYWAIT  = 1'b1;
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word assembly from the array at the completion edge. Error fetches never
  // touch the array and return zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd_word = '0;
    if (!w_req_err) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        w_rd_word[8*i +: 8] = r_mem[r_req_pc[IDX_W-1:0] + IDX_W'(i)];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request capture, fetch buffer and fault flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_req_pc    <= '0;
      r_buf_data  <= '0;
      r_buf_tag   <= '0;
      r_buf_valid <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req_pc <= PC;
      end

      if (w_complete) begin
        r_buf_data <= w_rd_word;
        r_buf_tag  <= r_req_pc;
        // A load to the same word on the completion edge is not captured
        // (the array is read before the write lands), so the buffered copy
        // is stale from the start.
        r_buf_valid <= !(w_ld_ok && (LOAD_ADDR == r_req_pc));
        r_fault     <= w_req_err;
      end else if (w_ld_ok && (LOAD_ADDR == r_buf_tag)) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Program-load port
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: the array has no reset: program contents must survive a CPU reset,
    // and a reset term would block RAM inference. Reset only gates the write.
    if (RESET && w_ld_ok) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        r_mem[LOAD_ADDR[IDX_W-1:0] + IDX_W'(i)] <= LOAD_DATA[8*i +: 8];
      end
    end
  end

  assign INSTRUCTION = r_buf_data;
  assign FAULT       = r_fault;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_ctrl
//   Self-checking bench for instr_mem_ctrl. The driver pushes the expected
//   instruction, fault flag and stall count for each fetch into a queue; a
//   monitor on the falling edge pops and compares every time the CPU would
//   consume an instruction (READ=1, BUSYWAIT=0). The reference is a byte array
//   plus a "last fetched word" record, updated from the load and fetch rules.
// -----------------------------------------------------------------------------
module tb_instr_mem_ctrl;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 1024;
  localparam int WB     = 4;
  localparam int LAT    = 2;

  logic        CLK;
  logic        RESET;
  logic [31:0] PC;
  logic        READ;
  logic [31:0] INSTRUCTION;
  logic        BUSYWAIT;
  logic        FAULT;
  logic        LOAD_EN;
  logic [31:0] LOAD_ADDR;
  logic [31:0] LOAD_DATA;

  instr_mem_ctrl #(
    .ADDR_W      (ADDR_W),
    .DEPTH_BYTES (DEPTH),
    .WORD_BYTES  (WB),
    .LATENCY     (LAT)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC          (PC),
    .READ        (READ),
    .INSTRUCTION (INSTRUCTION),
    .BUSYWAIT    (BUSYWAIT),
    .FAULT       (FAULT),
    .LOAD_EN     (LOAD_EN),
    .LOAD_ADDR   (LOAD_ADDR),
    .LOAD_DATA   (LOAD_DATA)
  );

  initial CLK = 1'b0;
  initial forever #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          stall;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks  = 0;
  int          n_errs    = 0;
  int          stall_cnt = 0;

  // Reference model: program bytes and the word the CPU last fetched.
  logic [7:0]  m_mem [DEPTH];
  logic [31:0] m_tag;
  bit          m_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] a);
    return ((a % WB) != 0) || ((longint'(a) + WB) > DEPTH);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] w;
    w = '0;
    if (!addr_err(a)) begin
      for (int i = 0; i < WB; i++) w[8*i +: 8] = m_mem[a + i];
    end
    return w;
  endfunction

  task automatic model_load(input logic [31:0] a, input logic [31:0] d);
    if (!addr_err(a)) begin
      for (int i = 0; i < WB; i++) m_mem[a + i] = d[8*i +: 8];
      if (m_valid && (m_tag == a)) m_valid = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: counts stalled cycles of the current request and checks each
  // instruction the CPU would consume.
  // ---------------------------------------------------------------------------
  always @(negedge CLK) begin
    if (READ === 1'b1) begin
      if (BUSYWAIT) begin
        stall_cnt++;
      end else begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL sb_unexpected: output 0x%08h with no expected entry", INSTRUCTION);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_instr", INSTRUCTION, mon_e.data);
          check("sb_fault", 32'(FAULT), 32'(mon_e.fault));
          check("sb_stall", stall_cnt, mon_e.stall);
        end
        stall_cnt = 0;
      end
    end else begin
      stall_cnt = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks: all are entered and left 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic wait_free();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (!BUSYWAIT) done = 1;
    end
    if (!done) check("fetch_timeout", 32'(BUSYWAIT), 32'd0);
    @(posedge CLK);
    #1;
    READ = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    exp_t e;
    e.data  = model_word(a);
    e.fault = addr_err(a);
    e.stall = (m_valid && (m_tag == a)) ? 0 : LAT + 1;
    sb_q.push_back(e);
    PC   = a;
    READ = 1'b1;
    wait_free();
    m_tag   = a;
    m_valid = 1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    LOAD_ADDR = a;
    LOAD_DATA = d;
    LOAD_EN   = 1'b1;
    @(posedge CLK);
    #1;
    LOAD_EN = 1'b0;
    model_load(a, d);
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0)      return 32'd1020;
    else if (r == 1) return 32'd1024;
    else if (r == 2) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
    else             return 32'($urandom_range(0, 15) * 4);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] old16;
    logic [31:0] prev;
    logic [31:0] a;
    exp_t        e;

    RESET = 1'b0; READ = 1'b0; PC = '0;
    LOAD_EN = 1'b0; LOAD_ADDR = '0; LOAD_DATA = '0;
    m_tag = '0; m_valid = 0;

    // Reset hold and reset values.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_instr", INSTRUCTION, 32'd0);
    check("rst_busy",  32'(BUSYWAIT), 32'd0);
    check("rst_fault", 32'(FAULT), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;

    // Fill the whole array so every later fetch has defined contents.
    for (int w = 0; w < DEPTH / WB; w++) load(32'(w * WB), $urandom());

    // 1: first fetch is a miss with LATENCY+1 stalled cycles.
    load(32'd0, 32'h0000_0009);
    load(32'd8, 32'h0206_0100);
    fetch(32'd0);

    // 2: repeat is a zero-latency hit; a new PC misses.
    fetch(32'd0);
    fetch(32'd8);

    // 3: PC changes mid-BUSY; the PC=4 word is still buffered, then 12 misses
    //    back to back, so 12 sees two full miss latencies of stall.
    e.data = model_word(32'd12); e.fault = 0; e.stall = 2 * (LAT + 1);
    sb_q.push_back(e);
    PC = 32'd4; READ = 1'b1;
    @(posedge CLK); #1;
    PC = 32'd12;
    repeat (LAT) @(posedge CLK);
    @(negedge CLK);
    check("t3_buf_word4", INSTRUCTION, model_word(32'd4));
    check("t3_busy_next", 32'(BUSYWAIT), 32'd1);
    wait_free();
    m_tag = 32'd12; m_valid = 1;

    // 4: error fetches return zero with FAULT, a good fetch clears it.
    fetch(32'd2);
    fetch(32'd1024);
    fetch(32'd0);

    // 5a: load during a hit to the same word: old word now, miss afterwards.
    LOAD_ADDR = 32'd0; LOAD_DATA = 32'hDEAD_BEEF; LOAD_EN = 1'b1;
    fetch(32'd0);
    LOAD_EN = 1'b0;
    model_load(32'd0, 32'hDEAD_BEEF);
    fetch(32'd0);

    // 5b: load one edge before completion is returned by the fetch.
    model_load(32'd4, 32'hA5A5_0004);
    fork
      fetch(32'd4);
      begin
        @(posedge CLK); #1;
        LOAD_ADDR = 32'd4; LOAD_DATA = 32'hA5A5_0004; LOAD_EN = 1'b1;
        @(posedge CLK); #1;
        LOAD_EN = 1'b0;
      end
    join

    // 5c: load on the completion edge: old word buffered but invalid, so the
    //     CPU stays stalled through a second miss that returns the new word.
    old16  = model_word(32'd16);
    e.data = 32'h1234_5678; e.fault = 0; e.stall = 2 * (LAT + 1);
    sb_q.push_back(e);
    PC = 32'd16; READ = 1'b1;
    @(posedge CLK); #1;
    repeat (LAT - 1) @(posedge CLK);
    #1;
    LOAD_ADDR = 32'd16; LOAD_DATA = 32'h1234_5678; LOAD_EN = 1'b1;
    @(posedge CLK); #1;
    LOAD_EN = 1'b0;
    model_load(32'd16, 32'h1234_5678);
    @(negedge CLK);
    check("t5_old_word", INSTRUCTION, old16);
    check("t5_still_busy", 32'(BUSYWAIT), 32'd1);
    wait_free();
    m_tag = 32'd16; m_valid = 1;

    // 6: reset mid-BUSY (with a load at the reset edge that must be dropped).
    fetch(32'd1024);
    PC = 32'd4; READ = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0; READ = 1'b0;
    LOAD_ADDR = 32'd8; LOAD_DATA = 32'hFFFF_FFFF; LOAD_EN = 1'b1;
    @(posedge CLK); #1;
    LOAD_EN = 1'b0;
    @(negedge CLK);
    check("t6_busy", 32'(BUSYWAIT), 32'd0);
    check("t6_instr", INSTRUCTION, 32'd0);
    check("t6_fault", 32'(FAULT), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    m_valid = 0;
    fetch(32'd1024);
    fetch(32'd8);

    // Randomised mix of loads (including dropped ones) and fetches.
    prev = 32'd0;
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        case ($urandom_range(0, 3))
          0:       a = 32'($urandom_range(0, DEPTH / WB - 1) * WB);
          1:       a = 32'($urandom_range(0, 1100));
          default: a = pick_addr();
        endcase
        load(a, $urandom());
      end else begin
        a = (r < 6) ? prev : pick_addr();
        fetch(a);
        prev = a;
      end
    end

    repeat (3) @(posedge CLK);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Parametrised instruction memory with a registered multi-cycle fetch path, a one-word fetch buffer and a program-load port. It replaces the bench-level behavioural instruction array and fixed fetch delay. It gives the CPU a stall handshake (`BUSYWAIT`) and makes fetch latency a design parameter instead of a `#` delay. Memory is byte-addressed; words are little-endian, so byte `PC` is the least significant byte.

## Interface
- `ADDR_W`, 32: PC and load-address width.
- `DEPTH_BYTES`, 1024: memory size in bytes. Must be a multiple of `WORD_BYTES`.
- `WORD_BYTES`, 4: bytes per instruction word. Instruction width is `8*WORD_BYTES`.
- `LATENCY`, 2: clock edges from an accepted miss to valid data. Must be ≥1.

Ports:
- `CLK` in 1: clock. All state changes on the rising edge.
- `RESET` in 1: synchronous, active-low reset. The block is in reset while `RESET`=0 at a rising edge.
- `PC` in `ADDR_W`: fetch byte address.
- `READ` in 1: fetch request, level-sensitive.
- `INSTRUCTION` out `8*WORD_BYTES`: fetched word.
- `BUSYWAIT` out 1: CPU must stall while this is high.
- `FAULT` out 1: the last completed fetch was misaligned or out of range.
- `LOAD_EN` in 1: write one word this cycle.
- `LOAD_ADDR` in `ADDR_W`: byte address for the load.
- `LOAD_DATA` in `8*WORD_BYTES`: word to write.

## Operation
- Storage: `DEPTH_BYTES` × 8-bit array. Reset does not clear it.
- Buffer state: `buf_data`, `buf_tag` (PC), `buf_valid`.
- Hit: `READ`=1, `buf_valid`=1 and `PC`==`buf_tag`.
- FSM states:
  - IDLE: on a hit, `INSTRUCTION`=`buf_data` and `BUSYWAIT`=0, both combinational. On a miss with `READ`=1, `BUSYWAIT`=1 combinationally. At the edge, latch `PC` into `req_pc`, load `cnt`=`LATENCY`, and go to BUSY.
  - BUSY: `BUSYWAIT`=1. Each edge decrements `cnt`. On the edge where `cnt`==1:
    - assemble the word `{mem[req_pc+WORD_BYTES-1] … mem[req_pc]}`;
    - write it to `buf_data`, set `buf_tag`=`req_pc`, set `buf_valid`=1;
    - go to IDLE.
- Error fetch: misaligned (`req_pc % WORD_BYTES`≠0) or out of range (`req_pc+WORD_BYTES > DEPTH_BYTES`).
  - The word is not read from the array.
  - Completion loads `buf_data`=0, sets `buf_valid`=1 and `FAULT`=1.
  - `FAULT` is registered and stays high until the next non-error completion or reset.
- `PC` and `READ` changes during BUSY are ignored. The in-flight request always completes. If `PC` differs from `buf_tag` afterwards, a new miss starts from IDLE.
- `READ`=0 in IDLE: `BUSYWAIT`=0 and `INSTRUCTION` holds `buf_data`.
- Load: at the edge with `LOAD_EN`=1, write `LOAD_DATA` little-endian at `LOAD_ADDR`.
  - Misaligned or out-of-range loads are dropped silently.
  - A load to `buf_tag` clears `buf_valid` at the same edge.
- Load vs. in-flight fetch: the array is sampled at the completion edge.
  - A load to `req_pc` landing before the completion edge is returned by the fetch.
  - A load to `req_pc` landing on the completion edge is not returned. The old word is buffered, `buf_valid` is cleared, and the next hit attempt misses.
- Load during a hit to the same word: `INSTRUCTION` shows the old `buf_data` that cycle. The next cycle misses.

## Timing
- Reset values: `INSTRUCTION`=0, `BUSYWAIT`=0, `FAULT`=0, `buf_valid`=0, state IDLE, `cnt`=0.
- Reset during BUSY aborts the fetch. `BUSYWAIT`=0 in the cycle after the reset edge and no buffer update occurs.
- Reset dominates `LOAD_EN` at the same edge: no write.
- Hit latency: 0 cycles, combinational.
- Miss latency: the request is accepted at edge E0. `BUSYWAIT` is high from the request cycle until edge E0+`LATENCY`. Data is valid and `BUSYWAIT`=0 after that edge. That is `LATENCY`+1 stalled cycles, counting the request cycle.
- Back-to-back misses: the next miss is accepted at the completion edge +1. There is no idle gap other than the IDLE decision cycle.
- `LATENCY`=1: BUSY lasts exactly one edge.

## Test plan
1. Reset hold, then load words 0x00000009 @0 and 0x02060100 @8. Fetch PC=0 with `LATENCY`=2 → `BUSYWAIT` high for 3 cycles, then `INSTRUCTION`=0x00000009 and `FAULT`=0.
2. Repeat fetch PC=0 with `READ` held → hit: `BUSYWAIT`=0 the same cycle and `INSTRUCTION`=0x00000009. Change to PC=8 → miss, then 0x02060100.
3. Miss on PC=4 while `PC` toggles to 12 mid-BUSY → returns mem[4..7] tagged 4. The next cycle misses on 12.
4. Misaligned PC=2 and PC=1024 → after the fetch latency `INSTRUCTION`=0 and `FAULT`=1. A later fetch of PC=0 clears `FAULT`.
5. Load 0xDEADBEEF @0 while PC=0 is a buffered hit → old word that cycle, then a miss returning 0xDEADBEEF. Load @4 one edge before a PC=4 fetch completes → new data returned.
6. Assert `RESET`=0 mid-BUSY → `BUSYWAIT`=0 after the edge and `buf_valid`=0. Array contents survive: a PC=8 fetch after reset still returns 0x02060100.
